// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle between a producer/consumer and fifo_sync_param.
interface fifo_sync_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              enable;
  logic              write;
  logic [DATA_W-1:0] data_in;
  logic              read;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  // Requester side: drives requests, observes data and status.
  modport master (
    output enable, write, data_in, read, err_clr,
    input  data_out, rd_valid, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  // FIFO side: consumes requests, produces data and status.
  modport slave (
    input  enable, write, data_in, read, err_clr,
    output data_out, rd_valid, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// read-valid strobe and sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic           clk,
  input  logic           rst,
  fifo_sync_param_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]     rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]     count_q, count_nxt;
  logic [DATA_W-1:0] data_out_q, data_out_nxt;
  logic              rd_valid_q, rd_valid_nxt;
  logic              overflow_q, overflow_nxt;
  logic              underflow_q, underflow_nxt;
  logic              empty_c, full_c;
  logic              rd_acc, wr_acc;

  // Status decodes of the registered occupancy.
  assign empty_c = (count_q == CW'(0));
  assign full_c  = (count_q == CW'(DEPTH));

  // Accept decisions and next-state computation from pre-edge state.
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count_q;
    data_out_nxt  = data_out_q;
    rd_valid_nxt  = 1'b0;
    overflow_nxt  = overflow_q;
    underflow_nxt = underflow_q;
    rd_acc        = 1'b0;
    wr_acc        = 1'b0;

    if (bus.enable) begin
      rd_acc = bus.read & ~empty_c;
      // A full FIFO still accepts a write when a read frees a slot this cycle.
      wr_acc = bus.write & (~full_c | rd_acc);

      if (rd_acc) begin
        data_out_nxt = mem[rd_ptr];
        rd_ptr_nxt   = rd_ptr + AW'(1);
        rd_valid_nxt = 1'b1;
      end
      if (wr_acc) begin
        wr_ptr_nxt = wr_ptr + AW'(1);
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count_q + CW'(1);
        2'b01:   count_nxt = count_q - CW'(1);
        default: count_nxt = count_q;
      endcase

      // Clear first so an error in the same cycle wins.
      if (bus.err_clr) begin
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
      end
      if (bus.write & ~wr_acc) overflow_nxt  = 1'b1;
      if (bus.read  & ~rd_acc) underflow_nxt = 1'b1;
    end
  end

  // Control and output state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count_q     <= count_nxt;
      data_out_q  <= data_out_nxt;
      rd_valid_q  <= rd_valid_nxt;
      overflow_q  <= overflow_nxt;
      underflow_q <= underflow_nxt;
    end
  end

  // Storage array; not reset, written only on an accepted write.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: vector table plus corner sequences,
// with a reference queue model and a read-data scoreboard.
module tb_fifo_sync_param;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AF_LEVEL = 6;
  localparam int unsigned AE_LEVEL = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_sync_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    int         cnt;
    logic [5:0] flg;   // {empty, full, almost_empty, almost_full, overflow, underflow}
    logic       rv;
    logic [7:0] dout;
  } vec_t;

  vec_t vt[$];

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq[$];   // reference FIFO contents
  logic [7:0] sb[$];   // expected read data, in issue order
  logic [7:0] m_dout;
  logic       m_rv, m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] din, input logic rd,
                              input logic clr, input int cnt, input logic [5:0] flg,
                              input logic rv, input logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
    v.cnt = cnt; v.flg = flg; v.rv = rv; v.dout = dout;
    return v;
  endfunction

  task automatic check_outputs();
    int n;
    logic [7:0] e;
    n = mq.size();
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    if (bus.rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underrun actual=rd_valid required=no_read_pending");
      end else begin
        e = sb.pop_front();
        chk("sb_data", 32'(bus.data_out), 32'(e));
      end
    end
    chk("data_out",     32'(bus.data_out),     32'(m_dout));
    chk("count",        32'(bus.count),        32'(n));
    chk("empty",        32'(bus.empty),        32'(n == 0));
    chk("full",         32'(bus.full),         32'(n == int'(DEPTH)));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= int'(AE_LEVEL)));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= int'(AF_LEVEL)));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_unf));
  endtask

  // One clock of stimulus; the model predicts acceptance from pre-edge state.
  task automatic cyc(input logic en, input logic wr, input logic [7:0] din,
                     input logic rd, input logic clr);
    bit ra, wa;
    bus.enable  = en;
    bus.write   = wr;
    bus.data_in = din;
    bus.read    = rd;
    bus.err_clr = clr;
    ra = en && rd && (mq.size() > 0);
    wa = en && wr && ((mq.size() < int'(DEPTH)) || ra);
    m_rv = ra;
    if (ra) begin
      sb.push_back(mq[0]);
      m_dout = mq[0];
      void'(mq.pop_front());
    end
    if (wa) mq.push_back(din);
    if (en) begin
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (wr && !wa) m_ovf = 1'b1;
      if (rd && !ra) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Reset with requests asserted to confirm reset priority.
  task automatic do_reset();
    rst          = 1'b1;
    bus.enable   = 1'b1;
    bus.write    = 1'b1;
    bus.data_in  = 8'h77;
    bus.read     = 1'b1;
    bus.err_clr  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    sb.delete();
    m_dout = 8'h00;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    bus.write = 1'b0;
    bus.read  = 1'b0;
    check_outputs();
  endtask

  initial begin
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.write   = 1'b0;
    bus.data_in = 8'h00;
    bus.read    = 1'b0;
    bus.err_clr = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_empty", 32'(bus.empty), 32'd1);
    chk("reset_ae",    32'(bus.almost_empty), 32'd1);

    // Fill, overflow, drain, underflow, clear.
    for (int i = 1; i <= 8; i++)
      vt.push_back(mk(1'b1, 8'(17 * i), 1'b0, 1'b0, i,
                      {1'b0, 1'(i == 8), 1'(i <= 2), 1'(i >= 6), 2'b00}, 1'b0, 8'h00));
    vt.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 8, 6'b010110, 1'b0, 8'h00));
    for (int j = 1; j <= 8; j++)
      vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8 - j,
                      {1'(j == 8), 1'b0, 1'((8 - j) <= 2), 1'((8 - j) >= 6), 2'b10},
                      1'b1, 8'(17 * j)));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 6'b101011, 1'b0, 8'h88));
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 6'b101000, 1'b0, 8'h88));

    foreach (vt[k]) begin
      cyc(1'b1, vt[k].wr, vt[k].din, vt[k].rd, vt[k].clr);
      chk("tbl_count", 32'(bus.count), 32'(vt[k].cnt));
      chk("tbl_flags", 32'({bus.empty, bus.full, bus.almost_empty, bus.almost_full,
                            bus.overflow, bus.underflow}), 32'(vt[k].flg));
      chk("tbl_rv",    32'(bus.rd_valid), 32'(vt[k].rv));
      chk("tbl_dout",  32'(bus.data_out), 32'(vt[k].dout));
    end

    // Full with simultaneous read and write returns the oldest word.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b1, 8'(17 * i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    chk("rw_full_dout",  32'(bus.data_out), 32'h11);
    chk("rw_full_count", 32'(bus.count), 32'd8);
    chk("rw_full_ovf",   32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_last", 32'(bus.data_out), 32'hA5);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Empty with read and write together: no fall-through.
    cyc(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
    chk("nofall_unf",   32'(bus.underflow), 32'd1);
    chk("nofall_count", 32'(bus.count), 32'd1);
    chk("nofall_rv",    32'(bus.rd_valid), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("nofall_data", 32'(bus.data_out), 32'h3C);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_unf", 32'(bus.underflow), 32'd0);

    // Error in the same cycle as err_clr stays set.
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("clr_vs_err", 32'(bus.underflow), 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Pointer wrap with write/read pairs.
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_data", 32'(bus.data_out), 32'(8'(8'h40 + k)));
    end

    // enable=0 holds everything and flags nothing.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hEE, 1'b1, 1'b1);
    chk("dis_count", 32'(bus.count), 32'd2);
    chk("dis_rv",    32'(bus.rd_valid), 32'd0);
    chk("dis_dout",  32'(bus.data_out), 32'h90);

    // Mid-stream reset at count 5.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    do_reset();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_rv",    32'(bus.rd_valid), 32'd0);

    // Operation resumes cleanly after reset.
    cyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_data", 32'(bus.data_out), 32'h5A);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous single-clock FIFO. It is the general-purpose successor of the team's 8x8 basic FIFO, generalised in data width and depth. It adds simultaneous read/write, an exact occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe and sticky overflow/underflow error flags. It sits between producer/consumer datapath stages in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 8, number of storage entries; power of two, >=2.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- Derived (localparam, not overridable): AW = $clog2(DEPTH); CW = AW+1.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global qualifier; when 0, the block holds all state.
- write  in  1  write request.
- data_in  in  DATA_W  write data.
- read  in  1  read request.
- err_clr  in  1  clears the sticky error flags.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  data_out updated this cycle (1-cycle pulse per accepted read).
- count  out  CW  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst=1 at posedge) has priority over enable and all requests. It sets wr_ptr=0, rd_ptr=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Storage array is not reset. Status after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0).
- enable=0 (rst=0): pointers, count, data_out and error flags hold; rd_valid=0; requests are ignored and flag no errors.
- Accept rules, all evaluated on pre-edge state with enable=1:
  - rd_acc = read & ~empty.
  - wr_acc = write & (~full | rd_acc).
- There is no fall-through: a read while empty is rejected even if a write is accepted in the same cycle.
- On rd_acc: data_out <= mem[rd_ptr]; rd_ptr advances; rd_valid=1 the next cycle. Read latency is 1 clock. data_out holds its last value otherwise.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr advances.
- Pointers are AW bits wide and wrap DEPTH-1 -> 0 naturally.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - count never exceeds DEPTH or goes below 0.
- Full with read and write together: both are accepted, count stays DEPTH, and the read returns the oldest entry (never the word being written).
- Error flags:
  - overflow <= 1 when write & ~wr_acc.
  - underflow <= 1 when read & ~rd_acc.
  - Both stay set until rst, or err_clr=1 with enable=1, which clears them. A new error in the same cycle as err_clr wins (the flag is set).
- Status flags (empty, full, almost_*) are combinational decodes of the registered count, so they are valid in the cycle after the update.

Test Plan:
- Reset, then write 0x11..0x88 (8 writes, DEPTH=8) -> count 1..8; almost_full at count 6; full=1 after the 8th write; overflow=0.
- 9th write 0xFF while full, read=0 -> count stays 8, overflow=1. The next 8 reads return 0x11..0x88 in order, each with a rd_valid pulse 1 cycle after read. Empty=1 at the end.
- Read while empty -> underflow=1, rd_valid=0, data_out holds 0x88. Then err_clr=1 for one cycle -> underflow=0.
- When full, assert read+write (data_in 0xA5) for one cycle -> data_out=0x11, count stays 8. Then drain: 0xA5 is the last word out.
- Empty with read+write 0x3C together -> read rejected (underflow=1), count=1. The next read returns 0x3C.
- Pointer wrap: run 20 single write/read pairs with incrementing data -> data out in order across the 7->0 wrap. Also assert rst mid-stream with count=5 -> count=0, empty=1, rd_valid=0 the next cycle; enable=0 cycles -> no state change.
